nav_command_sequencer: RTL and testbench
========================================

// Module: nav_command_sequencer
// PURPOSE
//  Pilot-side command sequencer that drives the one-hot mode_selector/pos_selector pair consumed by the
//  per-axis position datapath. Accepts pilot ops over a valid/ready handshake.
//  Sequences multi-cycle manoeuvres: warp charge, jump, cooldown and position reset.
//  Guarantees both selector buses are always legal one-hot codes.
// PARAMETERS
//  WARP_CHARGE_CYCLES  8   cycles in CHARGE before the jump; legal range 1..2**CNT_W-1
//  COOLDOWN_CYCLES     16  cycles in COOLDOWN after the jump; legal range 1..2**CNT_W-1
//  CNT_W               8   width of the internal phase counter
//  FUEL_INIT           255 fuel after reset (FUEL_GUARD_EN only)
//  WARP_FUEL_COST      64  fuel charged per accepted WARP (FUEL_GUARD_EN only)
// PORTS
//  clk            in   1  clock; all state updates on rising edge
//  rst            in   1  synchronous, active-high reset
//  cmd_valid      in   1  pilot op present
//  cmd_op         in   3  op code (see BEHAVIOUR)
//  cmd_ready      out  1  sequencer can accept an op this cycle
//  mode_selector  out  4  one-hot: 0001 stop, 0010 attack, 0100 defense, 1000 stealth
//  pos_selector   out  4  one-hot: 0001 reset, 0010 normal integrate, 0100 warp, 1000 never driven
//  busy           out  1  high in CHARGE/JUMP/COOLDOWN/RSTPOS
//  warp_active    out  1  high only in JUMP
//  cmd_err        out  1  one-cycle pulse on a rejected or reserved op
//  fuel_level     out  16 remaining fuel (port present only with FUEL_GUARD_EN)
// BEHAVIOUR
//  - Reset: state IDLE, mode=0001, pos=0001, cmd_ready=1, busy=0, warp_active=0, cmd_err=0, counter=0,
//    saved_mode=0001. rst has priority over every other event, including mid-warp (warp aborts).
//  - Handshake: op accepted on the edge where cmd_valid&&cmd_ready=1. All outputs are registered and
//    reflect the op on the next cycle (latency 1). cmd_ready=1 only in IDLE and CRUISE.
//  - States: IDLE, CRUISE, RSTPOS, CHARGE, JUMP, COOLDOWN.
//  - Op table (accepted in IDLE/CRUISE):
//    000 NOP      no change
//    001 STOP     mode 0001, pos 0010 -> IDLE
//    010 ATTACK   mode 0010, pos 0010 -> CRUISE
//    011 DEFENSE  mode 0100, pos 0010 -> CRUISE
//    100 STEALTH  mode 1000, pos 0010 -> CRUISE
//    101 WARP     saved_mode<=current mode -> CHARGE
//    110 RSTPOS   -> RSTPOS
//    111 reserved cmd_err pulse; no state change
//  - CHARGE: mode 0001, pos 0010 for exactly WARP_CHARGE_CYCLES cycles. Counter loads N-1 on entry and
//    exits at 0.
//  - JUMP: mode 0001, pos 0100, warp_active=1 for exactly 1 cycle.
//  - COOLDOWN: mode 0100, pos 0010 for exactly COOLDOWN_CYCLES cycles. Then mode<=saved_mode, pos 0010;
//    state is IDLE if saved_mode=0001, else CRUISE.
//  - RSTPOS: mode 0001, pos 0001 for 1 cycle, then pos 0010, IDLE.
//  - Invariants: selectors are exactly one-hot every cycle after reset. pos never 1000. No op accepted
//    while busy; the source holds cmd_valid/cmd_op.
// CONFIGURATION
//  FUEL_GUARD_EN defined:
//    - fuel_level port exists, reset to FUEL_INIT.
//    - Each cycle with mode=0010 decrements fuel by 1, saturating at 0.
//    - WARP with fuel<WARP_FUEL_COST: accepted, but state unchanged and cmd_err pulses.
//      Otherwise fuel -= WARP_FUEL_COST on acceptance.
//    - ATTACK with fuel=0: rejected the same way. Fuel reaching 0 in CRUISE/attack forces mode 0100 on
//      the next cycle.
//  FUEL_GUARD_EN undefined:
//    - No fuel_level port and no fuel logic; WARP and ATTACK are never rejected.
// TESTING
//  1. rst=1 for 2 cycles -> mode=0001, pos=0001, cmd_ready=1, busy=0. Release -> values hold until an op.
//  2. ATTACK accepted at cycle t -> t+1: mode=0010, pos=0010. STEALTH at t+3 -> t+4: mode=1000.
//  3. CRUISE/defense, WARP at t (defaults) -> t+1..t+8 CHARGE (busy=1, cmd_ready=0); t+9 pos=0100,
//     warp_active=1; t+10..t+25 mode=0100; t+26 mode=0100, CRUISE, cmd_ready=1.
//  4. WARP accepted, rst asserted mid-CHARGE -> next cycle mode=0001, pos=0001, IDLE, warp_active never high.
//  5. RSTPOS from IDLE -> exactly one cycle pos=0001, then 0010. op=111 -> one-cycle cmd_err, state unchanged.
//  6. FUEL_GUARD_EN, FUEL_INIT=100: WARP -> fuel=36. Second WARP -> cmd_err, no CHARGE. ATTACK 36 cycles ->
//     fuel=0, mode forced 0100.

Source files
------------

// File: rtl/nav_command_sequencer.sv
// nav_command_sequencer
//   Pilot-side command sequencer that drives the one-hot mode/position selector
//   pair for the per-axis position datapath. Ops arrive over valid/ready and are
//   sequenced into multi-cycle manoeuvres: warp (charge, jump, cooldown) and a
//   one-cycle position reset. Every output is registered, so an op accepted on
//   one edge shows up on the outputs in the following cycle.
//
//   Optional feature macro: FUEL_GUARD_EN
//     When defined, the block tracks fuel, exposes fuel_level, and rejects WARP
//     or ATTACK when there is not enough fuel. When undefined, none of that
//     logic or the fuel_level port exists.
module nav_command_sequencer #(
  parameter int WARP_CHARGE_CYCLES = 8,
  parameter int COOLDOWN_CYCLES    = 16,
  parameter int CNT_W              = 8
`ifdef FUEL_GUARD_EN
  ,
  parameter int FUEL_INIT          = 255,
  parameter int WARP_FUEL_COST     = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  output logic        cmd_ready,
  output logic [3:0]  mode_selector,
  output logic [3:0]  pos_selector,
  output logic        busy,
  output logic        warp_active,
  output logic        cmd_err
`ifdef FUEL_GUARD_EN
  ,
  output logic [15:0] fuel_level
`endif
);

  // Selector codes
  localparam logic [3:0] MODE_STOP    = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;
  localparam logic [3:0] POS_RESET    = 4'b0001;
  localparam logic [3:0] POS_NORMAL   = 4'b0010;
  localparam logic [3:0] POS_WARP     = 4'b0100;

  // Op codes
  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_STOP    = 3'b001;
  localparam logic [2:0] OP_ATTACK  = 3'b010;
  localparam logic [2:0] OP_DEFENSE = 3'b011;
  localparam logic [2:0] OP_STEALTH = 3'b100;
  localparam logic [2:0] OP_WARP    = 3'b101;
  localparam logic [2:0] OP_RSTPOS  = 3'b110;

  // Phase counter loads: the counter starts at N-1 and the phase ends when it reads 0
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CHARGE_LOAD = CNT_W'(WARP_CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CRUISE   = 3'd1,
    S_RSTPOS   = 3'd2,
    S_CHARGE   = 3'd3,
    S_JUMP     = 3'd4,
    S_COOLDOWN = 3'd5
  } state_t;

  // After cooldown the craft settles in IDLE only if it was stopped before the warp
  function automatic state_t home_state(input logic [3:0] mode);
    state_t s;
    if (mode == MODE_STOP) begin
      s = S_IDLE;
    end else begin
      s = S_CRUISE;
    end
    return s;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       saved_mode_r, saved_mode_s;
  logic [3:0]       mode_r, mode_s;
  logic [3:0]       pos_r, pos_s;
  logic             busy_r, busy_s;
  logic             warp_r, warp_s;
  logic             err_r, err_s;
  logic             ready_r, ready_s;
  logic             accept_s;

  // Fuel qualifiers seen by the op decoder
  logic             warp_ok_s;
  logic             attack_ok_s;
  logic             fuel_empty_s;

  assign accept_s = cmd_valid && ready_r;

`ifdef FUEL_GUARD_EN
  localparam logic [15:0] FUEL_RESET = 16'(FUEL_INIT);
  localparam logic [15:0] WARP_COST  = 16'(WARP_FUEL_COST);

  logic [15:0] fuel_r, fuel_s, fuel_dec_s;
  logic        warp_take_s;

  assign warp_ok_s    = (fuel_r >= WARP_COST);
  assign attack_ok_s  = (fuel_r != 16'd0);
  assign fuel_empty_s = (fuel_r == 16'd0);
  assign warp_take_s  = accept_s && (cmd_op == OP_WARP) && warp_ok_s;

  // Fuel burn: one unit per attack cycle, then the warp cost, both floored at zero
  always_comb begin
    fuel_dec_s = fuel_r;
    fuel_s     = fuel_r;
    if ((mode_r == MODE_ATTACK) && (fuel_r != 16'd0)) begin
      fuel_dec_s = fuel_r - 16'd1;
    end else begin
      fuel_dec_s = fuel_r;
    end
    if (warp_take_s) begin
      if (fuel_dec_s >= WARP_COST) begin
        fuel_s = fuel_dec_s - WARP_COST;
      end else begin
        fuel_s = 16'd0;
      end
    end else begin
      fuel_s = fuel_dec_s;
    end
  end

  // Fuel register
  always_ff @(posedge clk) begin
    if (rst) begin
      fuel_r <= FUEL_RESET;
    end else begin
      fuel_r <= fuel_s;
    end
  end

  assign fuel_level = fuel_r;
`else
  assign warp_ok_s    = 1'b1;
  assign attack_ok_s  = 1'b1;
  assign fuel_empty_s = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these values
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    saved_mode_s = saved_mode_r;
    mode_s       = mode_r;
    pos_s        = pos_r;
    err_s        = 1'b0;

    case (state_r)
      S_IDLE, S_CRUISE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_NOP: begin
              state_s = state_r;
            end
            OP_STOP: begin
              mode_s  = MODE_STOP;
              pos_s   = POS_NORMAL;
              state_s = S_IDLE;
            end
            OP_ATTACK: begin
              if (attack_ok_s) begin
                mode_s  = MODE_ATTACK;
                pos_s   = POS_NORMAL;
                state_s = S_CRUISE;
              end else begin
                err_s = 1'b1;
              end
            end
            OP_DEFENSE: begin
              mode_s  = MODE_DEFENSE;
              pos_s   = POS_NORMAL;
              state_s = S_CRUISE;
            end
            OP_STEALTH: begin
              mode_s  = MODE_STEALTH;
              pos_s   = POS_NORMAL;
              state_s = S_CRUISE;
            end
            OP_WARP: begin
              if (warp_ok_s) begin
                saved_mode_s = mode_r;
                mode_s       = MODE_STOP;
                pos_s        = POS_NORMAL;
                cnt_s        = CHARGE_LOAD;
                state_s      = S_CHARGE;
              end else begin
                err_s = 1'b1;
              end
            end
            OP_RSTPOS: begin
              mode_s  = MODE_STOP;
              pos_s   = POS_RESET;
              state_s = S_RSTPOS;
            end
            default: begin
              err_s = 1'b1;
            end
          endcase
        end else begin
          state_s = state_r;
        end
        // An attack run that has burned the last fuel drops to defense
        if ((mode_s == MODE_ATTACK) && fuel_empty_s) begin
          mode_s = MODE_DEFENSE;
        end else begin
          mode_s = mode_s;
        end
      end
      S_CHARGE: begin
        if (cnt_r == CNT_ZERO) begin
          mode_s  = MODE_STOP;
          pos_s   = POS_WARP;
          state_s = S_JUMP;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_JUMP: begin
        mode_s  = MODE_DEFENSE;
        pos_s   = POS_NORMAL;
        cnt_s   = COOL_LOAD;
        state_s = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (cnt_r == CNT_ZERO) begin
          mode_s  = saved_mode_r;
          pos_s   = POS_NORMAL;
          state_s = home_state(saved_mode_r);
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_RSTPOS: begin
        mode_s  = MODE_STOP;
        pos_s   = POS_NORMAL;
        state_s = S_IDLE;
      end
      default: begin
        mode_s       = MODE_STOP;
        pos_s        = POS_RESET;
        cnt_s        = CNT_ZERO;
        saved_mode_s = MODE_STOP;
        state_s      = S_IDLE;
      end
    endcase

    busy_s  = (state_s == S_CHARGE) || (state_s == S_JUMP) ||
              (state_s == S_COOLDOWN) || (state_s == S_RSTPOS);
    warp_s  = (state_s == S_JUMP);
    ready_s = (state_s == S_IDLE) || (state_s == S_CRUISE);
  end

  // State, phase counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= CNT_ZERO;
      saved_mode_r <= MODE_STOP;
      mode_r       <= MODE_STOP;
      pos_r        <= POS_RESET;
      busy_r       <= 1'b0;
      warp_r       <= 1'b0;
      err_r        <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      saved_mode_r <= saved_mode_s;
      mode_r       <= mode_s;
      pos_r        <= pos_s;
      busy_r       <= busy_s;
      warp_r       <= warp_s;
      err_r        <= err_s;
      ready_r      <= ready_s;
    end
  end

  assign cmd_ready     = ready_r;
  assign mode_selector = mode_r;
  assign pos_selector  = pos_r;
  assign busy          = busy_r;
  assign warp_active   = warp_r;
  assign cmd_err       = err_r;

endmodule

// File: tb/tb_nav_command_sequencer.sv
// Self-checking bench for nav_command_sequencer: directed scenarios with
// literal expectations, then randomized ops and resets compared every cycle
// against a timeline model of the expected outputs. Define FUEL_GUARD_EN to
// exercise the fuel-guarded build.
module tb_nav_command_sequencer;

  localparam int N     = 8;
  localparam int M     = 16;
  localparam int COST  = 64;
  localparam int FINIT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic        cmd_ready;
  logic [3:0]  mode_selector;
  logic [3:0]  pos_selector;
  logic        busy;
  logic        warp_active;
  logic        cmd_err;
`ifdef FUEL_GUARD_EN
  logic [15:0] fuel_level;
  int          fuel_m = 0;
`endif

  typedef struct packed {
    logic [3:0] mode;
    logic [3:0] pos;
    logic       busy;
    logic       warp;
    logic       ready;
    logic       err;
  } out_t;

  out_t       exp_v;
  out_t       got_v;
  out_t       plan[$];
  logic [3:0] saved;
  bit         model_ok = 1'b0;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

`ifdef FUEL_GUARD_EN
  nav_command_sequencer #(.FUEL_INIT(FINIT)) dut (
`else
  nav_command_sequencer dut (
`endif
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_ready     (cmd_ready),
    .mode_selector (mode_selector),
    .pos_selector  (pos_selector),
    .busy          (busy),
    .warp_active   (warp_active),
    .cmd_err       (cmd_err)
`ifdef FUEL_GUARD_EN
    ,
    .fuel_level    (fuel_level)
`endif
  );

  function automatic out_t mk(input logic [3:0] m, input logic [3:0] p,
                              input logic b, input logic w, input logic r, input logic e);
    out_t o;
    o.mode = m; o.pos = p; o.busy = b; o.warp = w; o.ready = r; o.err = e;
    return o;
  endfunction

  // Model: expected outputs for the cycle after each edge; multi-cycle
  // manoeuvres are pre-computed as a timeline of output vectors.
  task automatic model_step();
    out_t nxt;
    bit   take_warp;
    bit   no_fuel;
    bit   short_fuel;
    take_warp = 1'b0;
    no_fuel = 1'b0;
    short_fuel = 1'b0;
`ifdef FUEL_GUARD_EN
    no_fuel = (fuel_m == 0);
    short_fuel = (fuel_m < COST);
`endif
    if (rst) begin
      nxt = mk(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
      plan.delete();
      saved = 4'b0001;
      model_ok = 1'b1;
`ifdef FUEL_GUARD_EN
      fuel_m = FINIT;
`endif
    end else if (plan.size() > 0) begin
      nxt = plan.pop_front();
    end else begin
      nxt = exp_v;
      nxt.err = 1'b0;
      if (cmd_valid && exp_v.ready) begin
        case (cmd_op)
          3'd1: begin nxt.mode = 4'b0001; nxt.pos = 4'b0010; end
          3'd2: begin
            if (no_fuel) nxt.err = 1'b1;
            else begin nxt.mode = 4'b0010; nxt.pos = 4'b0010; end
          end
          3'd3: begin nxt.mode = 4'b0100; nxt.pos = 4'b0010; end
          3'd4: begin nxt.mode = 4'b1000; nxt.pos = 4'b0010; end
          3'd5: begin
            if (short_fuel) nxt.err = 1'b1;
            else begin
              take_warp = 1'b1;
              saved = exp_v.mode;
              nxt = mk(4'b0001, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
              for (int k = 1; k < N; k++) plan.push_back(mk(4'b0001, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0));
              plan.push_back(mk(4'b0001, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0));
              for (int k = 0; k < M; k++) plan.push_back(mk(4'b0100, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0));
              plan.push_back(mk(saved, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0));
            end
          end
          3'd6: begin
            nxt = mk(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
            plan.push_back(mk(4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0));
          end
          3'd7: nxt.err = 1'b1;
          default: ;
        endcase
      end
      if (nxt.mode == 4'b0010 && no_fuel) nxt.mode = 4'b0100;
    end
`ifdef FUEL_GUARD_EN
    if (!rst) begin
      fuel_m = fuel_m - ((exp_v.mode == 4'b0010) ? 1 : 0) - (take_warp ? COST : 0);
      if (fuel_m < 0) fuel_m = 0;
    end
`endif
    exp_v = nxt;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      got_v = mk(mode_selector, pos_selector, busy, warp_active, cmd_ready, cmd_err);
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle %0d outputs: got mode=%b pos=%b busy=%b warp=%b ready=%b err=%b, want mode=%b pos=%b busy=%b warp=%b ready=%b err=%b",
                 cyc, got_v.mode, got_v.pos, got_v.busy, got_v.warp, got_v.ready, got_v.err,
                 exp_v.mode, exp_v.pos, exp_v.busy, exp_v.warp, exp_v.ready, exp_v.err);
      end
      checks++;
      if (!($onehot(mode_selector) && $onehot(pos_selector) && pos_selector != 4'b1000)) begin
        errors++;
        $display("FAIL cycle %0d onehot: got mode=%b pos=%b, want legal one-hot codes", cyc, mode_selector, pos_selector);
      end
`ifdef FUEL_GUARD_EN
      checks++;
      if (fuel_level !== fuel_m[15:0]) begin
        errors++;
        $display("FAIL cycle %0d fuel: got %0d want %0d", cyc, fuel_level, fuel_m);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, want 1", cmd_ready, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and hold
    repeat (2) @(negedge clk);
    chk("reset mode", 16'(mode_selector), 16'h1);
    chk("reset pos", 16'(pos_selector), 16'h1);
    chk("reset ready", 16'(cmd_ready), 16'h1);
    chk("reset busy", 16'(busy), 16'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold pos", 16'(pos_selector), 16'h1);
    chk("hold mode", 16'(mode_selector), 16'h1);

`ifdef FUEL_GUARD_EN
    chk("fuel init", fuel_level, 16'd100);
    send(3'd5);
    chk("fuel after warp", fuel_level, 16'd36);
    wait_ready(40);
    send(3'd5);
    chk("short warp err", 16'(cmd_err), 16'h1);
    chk("short warp busy", 16'(busy), 16'h0);
    send(3'd2);
    chk("attack mode", 16'(mode_selector), 16'h2);
    repeat (36) @(negedge clk);
    chk("fuel drained", fuel_level, 16'd0);
    @(negedge clk);
    chk("forced defense", 16'(mode_selector), 16'h4);
    send(3'd2);
    chk("empty attack err", 16'(cmd_err), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    // Attack then stealth
    send(3'd2);
    chk("attack mode", 16'(mode_selector), 16'h2);
    chk("attack pos", 16'(pos_selector), 16'h2);
    @(negedge clk);
    send(3'd4);
    chk("stealth mode", 16'(mode_selector), 16'h8);

    // Full warp from defense
    send(3'd3);
    chk("defense mode", 16'(mode_selector), 16'h4);
    send(3'd5);
    chk("charge busy", 16'(busy), 16'h1);
    chk("charge ready", 16'(cmd_ready), 16'h0);
    chk("charge mode", 16'(mode_selector), 16'h1);
    repeat (7) @(negedge clk);
    chk("charge last pos", 16'(pos_selector), 16'h2);
    chk("charge last warp", 16'(warp_active), 16'h0);
    @(negedge clk);
    chk("jump pos", 16'(pos_selector), 16'h4);
    chk("jump warp", 16'(warp_active), 16'h1);
    repeat (16) @(negedge clk);
    chk("cool last mode", 16'(mode_selector), 16'h4);
    chk("cool last busy", 16'(busy), 16'h1);
    @(negedge clk);
    chk("after warp mode", 16'(mode_selector), 16'h4);
    chk("after warp ready", 16'(cmd_ready), 16'h1);
    chk("after warp busy", 16'(busy), 16'h0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-charge aborts the warp
    send(3'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort mode", 16'(mode_selector), 16'h1);
    chk("abort pos", 16'(pos_selector), 16'h1);
    chk("abort ready", 16'(cmd_ready), 16'h1);
    chk("abort warp", 16'(warp_active), 16'h0);

    // Position reset and reserved op
    send(3'd6);
    chk("rstpos pos", 16'(pos_selector), 16'h1);
    chk("rstpos busy", 16'(busy), 16'h1);
    @(negedge clk);
    chk("rstpos done pos", 16'(pos_selector), 16'h2);
    chk("rstpos done ready", 16'(cmd_ready), 16'h1);
    send(3'd7);
    chk("reserved err", 16'(cmd_err), 16'h1);
    chk("reserved pos", 16'(pos_selector), 16'h2);
    @(negedge clk);
    chk("reserved err pulse", 16'(cmd_err), 16'h0);

    // Randomized ops with occasional resets; the source holds while stalled
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!(cmd_valid && !cmd_ready)) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
